load_store_unit: RTL and testbench

Sits between the MEM pipeline stage and `dataMem`, converting MIPS load/store requests (LB/LBU/LH/LHU/LW, SB/SH/SW) into word accesses on `dataMem`'s 10-bit word-addressed port. Sub-word stores use a read-modify-write sequence, and loads are extracted and sign- or zero-extended. The unit stalls the pipeline until each access completes and flags misaligned accesses without touching memory.

---
 rtl/load_store_unit.sv | 196 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts MIPS byte-addressed loads/stores (LB/LBU/LH/LHU/LW, SB/SH/SW)
//   into word accesses on a word-addressed data memory. Sub-word stores are
//   done as read-modify-write; loads are lane-extracted and sign/zero
//   extended. Misaligned accesses fault without touching memory.
//
// Ports
//   clk, resetN          clock, synchronous active-low reset
//   req                  memory op present (held with operands until done)
//   isStore              1 = store, 0 = load
//   size                 00 byte, 01 half, 10/11 word
//   unsignedLoad         zero-extend sub-word loads
//   byteAddr, storeData  effective byte address and store operand
//   loadData             registered, extended load result
//   done, misaligned     one-cycle completion / fault pulses
//   stall                req & ~done
//   memAddress, memDataIn, memWrite, memRead, memDataOut  data memory port
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              req,
  input  logic              isStore,
  input  logic [1:0]        size,
  input  logic              unsignedLoad,
  input  logic [31:0]       byteAddr,
  input  logic [31:0]       storeData,
  output logic [31:0]       loadData,
  output logic              done,
  output logic              misaligned,
  output logic              stall,
  output logic [ADDR_W-1:0] memAddress,
  output logic [31:0]       memDataIn,
  output logic              memWrite,
  output logic              memRead,
  input  logic [31:0]       memDataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              is_store_q, is_store_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       load_q, load_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;

  logic              start;
  logic              in_misaligned;
  logic              write_raw;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       extended;
  logic [31:0]       merged;

  // Address bits above the memory window alias and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^byteAddr[31:ADDR_W+2];

  // The ~done term keeps the still-asserted req of the done cycle from
  // launching the same op a second time.
  assign start = (state_q == IDLE) && req && !done_q;
  assign in_misaligned = ((size == 2'b01) && byteAddr[0]) ||
                         (size[1] && (byteAddr[1:0] != 2'b00));

  // Big-endian lane selection: offset 0 is the most significant byte.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = memDataOut[31:24];
      2'd1:    lane_byte = memDataOut[23:16];
      2'd2:    lane_byte = memDataOut[15:8];
      default: lane_byte = memDataOut[7:0];
    endcase
    lane_half = addr_q[1] ? memDataOut[15:0] : memDataOut[31:16];
    if (size_q[1]) begin
      extended = memDataOut;
    end else if (size_q[0]) begin
      extended = {{16{!unsigned_q && lane_half[15]}}, lane_half};
    end else begin
      extended = {{24{!unsigned_q && lane_byte[7]}}, lane_byte};
    end
  end

  // Read-modify-write merge of the stored lane into the fetched word.
  always_comb begin
    merged = word_q;
    if (size_q[0]) begin
      if (addr_q[1]) merged[15:0]  = store_q[15:0];
      else           merged[31:16] = store_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[31:24] = store_q[7:0];
        2'd1:    merged[23:16] = store_q[7:0];
        2'd2:    merged[15:8]  = store_q[7:0];
        default: merged[7:0]   = store_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    size_d     = size_q;
    is_store_d = is_store_q;
    unsigned_d = unsigned_q;
    word_d     = word_q;
    load_d     = load_q;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    memRead    = 1'b0;
    write_raw  = 1'b0;
    memDataIn  = store_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = byteAddr[ADDR_W+1:0];
          store_d    = storeData;
          size_d     = size;
          is_store_d = isStore;
          unsigned_d = unsignedLoad;
          if (in_misaligned) begin
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (is_store_q && size_q[1]) begin
          write_raw = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (!is_store_q) begin
          memRead = 1'b1;
          load_d  = extended;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          memRead = 1'b1;
          word_d  = memDataOut;
          state_d = WRITE;
        end
      end
      WRITE: begin
        write_raw = 1'b1;
        memDataIn = merged;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with resetN stops a write that is interrupted by reset from
  // committing at the same edge.
  assign memWrite   = write_raw && resetN;
  assign memAddress = addr_q[ADDR_W+1:2];
  assign loadData   = load_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign stall      = req && !done_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      store_q    <= '0;
      size_q     <= '0;
      is_store_q <= 1'b0;
      unsigned_q <= 1'b0;
      word_q     <= '0;
      load_q     <= '0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      size_q     <= size_d;
      is_store_q <= is_store_d;
      unsigned_q <= unsigned_d;
      word_q     <= word_d;
      load_q     <= load_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              resetN;
  logic              req;
  logic              isStore;
  logic [1:0]        size;
  logic              unsignedLoad;
  logic [31:0]       byteAddr;
  logic [31:0]       storeData;
  logic [31:0]       loadData;
  logic              done;
  logic              misaligned;
  logic              stall;
  logic [ADDR_W-1:0] memAddress;
  logic [31:0]       memDataIn;
  logic              memWrite;
  logic              memRead;
  logic [31:0]       memDataOut;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetN(resetN), .req(req), .isStore(isStore), .size(size),
    .unsignedLoad(unsignedLoad), .byteAddr(byteAddr), .storeData(storeData),
    .loadData(loadData), .done(done), .misaligned(misaligned), .stall(stall),
    .memAddress(memAddress), .memDataIn(memDataIn), .memWrite(memWrite),
    .memRead(memRead), .memDataOut(memDataOut)
  );

  // Data memory: combinational read, write on rising edge, plus a backdoor
  // port for preloading words.
  logic [31:0] dmem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;
  assign memDataOut = dmem[memAddress];
  always @(posedge clk) begin
    if (memWrite) dmem[memAddress] <= memDataIn;
    else if (bd_we) dmem[bd_addr] <= bd_data;
  end

  // Behavioural model state
  logic [31:0] ref_mem [0:1023];
  logic [31:0] model_load;

  // Per-cycle expectations
  logic        chk_en;
  logic        exp_read, exp_write, exp_done, exp_mis, exp_stall, exp_bus;
  logic [9:0]  exp_addr;
  logic [31:0] exp_wdata;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, expv, $time);
  endtask

  function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic uns);
    int sh;
    logic [31:0] v;
    if (sz[1]) return w;
    if (sz == 2'b00) begin
      sh = 8 * (3 - int'(off));
      v = (w >> sh) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      sh = off[1] ? 0 : 16;
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic half,
                                             input logic [1:0] off, input logic [31:0] d);
    int sh;
    logic [31:0] mask;
    if (half) begin
      sh = off[1] ? 0 : 16;
      mask = 32'hFFFF << sh;
    end else begin
      sh = 8 * (3 - int'(off));
      mask = 32'hFF << sh;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("memRead", 32'(memRead), 32'(exp_read));
      check("memWrite", 32'(memWrite), 32'(exp_write));
      check("done", 32'(done), 32'(exp_done));
      check("misaligned", 32'(misaligned), 32'(exp_mis));
      check("stall", 32'(stall), 32'(exp_stall));
      check("loadData", loadData, model_load);
      check("strobe_excl", 32'(memRead & memWrite), 32'd0);
      if (exp_read || exp_write || exp_bus) check("memAddress", 32'(memAddress), 32'(exp_addr));
      if (exp_write || exp_bus) check("memDataIn", memDataIn, exp_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_exp();
    exp_read = 0; exp_write = 0; exp_done = 0; exp_mis = 0; exp_stall = 0; exp_bus = 0;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    bd_we = 1; bd_addr = a; bd_data = d;
    step();
    bd_we = 0;
    ref_mem[a] = d;
  endtask

  task automatic run_op(input string nm, input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
    logic [9:0]  w;
    logic [1:0]  off;
    logic        bad;
    logic [31:0] nw;
    w = a[11:2];
    off = a[1:0];
    bad = ((sz == 2'b01) && a[0]) || (sz[1] && (off != 2'b00));
    req = 1; isStore = st; size = sz; unsignedLoad = uns; byteAddr = a; storeData = d;
    idle_exp();
    exp_stall = 1;
    step();
    if (bad) begin
      exp_done = 1; exp_mis = 1; exp_stall = 0;
    end else begin
      exp_addr = w; exp_wdata = d;
      if (st && sz[1]) exp_write = 1;
      else exp_read = 1;
      step();
      exp_read = 0; exp_write = 0;
      if (st && !sz[1]) begin
        nw = merge_lane(ref_mem[w], sz[0], off, d);
        exp_write = 1; exp_wdata = nw;
        step();
        exp_write = 0;
        ref_mem[w] = nw;
      end else if (st) begin
        ref_mem[w] = d;
      end else begin
        model_load = load_lane(ref_mem[w], sz, off, uns);
      end
      exp_done = 1; exp_stall = 0;
    end
    step();
    req = 0;
    idle_exp();
    $display("op %-6s addr=%h data=%h -> loadData=%h mis=%0d", nm, a, d, loadData, bad);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_en = 0; bd_we = 0; bd_addr = '0; bd_data = '0;
    resetN = 0; req = 1; isStore = 1; size = 2'b10; unsignedLoad = 0;
    byteAddr = 32'h8; storeData = 32'h12345678;
    model_load = 32'h0; exp_addr = '0; exp_wdata = '0;
    idle_exp();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

    // Reset held for two cycles with req asserted
    step();
    chk_en = 1; exp_stall = 1; exp_bus = 1; exp_addr = '0; exp_wdata = '0;
    step();
    resetN = 1; req = 0;
    idle_exp();
    $display("reset: two cycles with req high");
    step();

    // Word load
    poke(10'd2, 32'h11223344);
    run_op("LW", 0, 2'b10, 0, 32'h8, 32'h0);
    check("lit_LW", loadData, 32'h11223344);

    // Sub-word loads
    poke(10'd2, 32'h1180F344);
    run_op("LB", 0, 2'b00, 0, 32'h9, 32'h0);
    check("lit_LB", loadData, 32'hFFFFFF80);
    run_op("LBU", 0, 2'b00, 1, 32'h9, 32'h0);
    check("lit_LBU", loadData, 32'h00000080);
    run_op("LH", 0, 2'b01, 0, 32'hA, 32'h0);
    check("lit_LH", loadData, 32'hFFFFF344);
    run_op("LHU", 0, 2'b01, 1, 32'h8, 32'h0);
    check("lit_LHU", loadData, 32'h00001180);
    run_op("LB0", 0, 2'b00, 0, 32'h8, 32'h0);
    check("lit_LB0", loadData, 32'h00000011);
    run_op("LW11", 0, 2'b11, 1, 32'h8, 32'h0);
    check("lit_LW11", loadData, 32'h1180F344);

    // Sub-word stores
    poke(10'd2, 32'h11223344);
    run_op("SB", 1, 2'b00, 0, 32'hB, 32'h000000AA);
    check("lit_SB_mem", dmem[2], 32'h112233AA);
    run_op("SH", 1, 2'b01, 0, 32'h8, 32'h0000BEEF);
    check("lit_SH_mem", dmem[2], 32'hBEEF33AA);
    check("lit_SH_keep_load", loadData, 32'h1180F344);

    // Misaligned accesses
    run_op("LWmis", 0, 2'b10, 0, 32'hA, 32'h0);
    check("lit_mis_load", loadData, 32'h1180F344);
    run_op("SHmis", 1, 2'b01, 0, 32'h9, 32'h0000DEAD);
    check("lit_mis_mem", dmem[2], 32'hBEEF33AA);

    // Address wrap and top word
    run_op("SWwrap", 1, 2'b10, 0, 32'h00001000, 32'hCAFEF00D);
    check("lit_wrap_mem", dmem[0], 32'hCAFEF00D);
    poke(10'd1023, 32'h0BADBEEF);
    run_op("LWtop", 0, 2'b10, 0, 32'hFFFFFFFC, 32'h0);
    check("lit_LWtop", loadData, 32'h0BADBEEF);

    // Reset arriving in the WRITE cycle of an SB
    poke(10'd2, 32'h11223344);
    req = 1; isStore = 1; size = 2'b00; unsignedLoad = 0; byteAddr = 32'hB; storeData = 32'h55;
    idle_exp(); exp_stall = 1;
    step();
    exp_read = 1; exp_addr = 10'd2;
    step();
    resetN = 0;
    exp_read = 0; exp_write = 0;
    step();
    resetN = 1; req = 0; model_load = 32'h0;
    idle_exp(); exp_bus = 1; exp_addr = '0; exp_wdata = '0;
    step();
    exp_bus = 0;
    $display("op SBrst addr=0000000b data=00000055 -> reset during write");
    check("lit_rst_mem", dmem[2], 32'h11223344);
    step();
    run_op("LW", 0, 2'b10, 0, 32'h8, 32'h0);
    check("lit_LW_after_rst", loadData, 32'h11223344);

    step();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
